// File: rtl/network_mac_pipe_signed.sv
// Pipelined signed multiply / multiply-accumulate unit for the network datapath.
// A product pipe of NUM_STAGE registers feeds one output stage. The output stage
// either forwards the sign-extended product (mode 0) or folds it into a saturating
// dot-product accumulator (mode 1). A single stall term (out_vld & ~out_rdy)
// freezes every register, so beats are never lost or duplicated.
module network_mac_pipe_signed #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 11,
  parameter int NUM_STAGE = 3,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        dout_ovf
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Flow control
  logic stall;
  logic adv;

  // Product pipe
  logic signed [P_WIDTH-1:0] prod;
  logic signed [P_WIDTH-1:0] p_q [NUM_STAGE];
  logic signed [P_WIDTH-1:0] p_d [NUM_STAGE];
  logic [NUM_STAGE-1:0]      vld_q,  vld_d;
  logic [NUM_STAGE-1:0]      mode_q, mode_d;
  logic [NUM_STAGE-1:0]      last_q, last_d;

  // Output stage and accumulator
  logic                        out_vld_q,  out_vld_d;
  logic signed [ACC_WIDTH-1:0] dout_q,     dout_d;
  logic                        dout_ovf_q, dout_ovf_d;
  logic signed [ACC_WIDTH-1:0] acc_q,      acc_d;
  logic                        acc_open_q, acc_open_d;
  logic                        ovf_s_q,    ovf_s_d;

  // Accumulate datapath
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        clamped;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic                        ovf_base;

  assign stall    = out_vld_q & ~out_rdy;
  assign adv      = ~stall;
  assign in_rdy   = ~stall & ~ap_rst;
  assign out_vld  = out_vld_q;
  assign dout     = dout_q;
  assign dout_ovf = dout_ovf_q;

  // Full-precision signed product; both operands are sign-extended to the product width first.
  assign prod = P_WIDTH'(din0) * P_WIDTH'(din1);

  // Shift the product pipe by one slot whenever the output is not stalled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    vld_d  = vld_q;
    mode_d = mode_q;
    last_d = last_q;
    p_d    = p_q;
    if (adv) begin
      vld_d[0]  = in_vld & in_rdy;
      mode_d[0] = in_mode;
      last_d[0] = in_last;
      p_d[0]    = prod;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i]  = vld_q[i-1];
        mode_d[i] = mode_q[i-1];
        last_d[i] = last_q[i-1];
        p_d[i]    = p_q[i-1];
      end
    end
  end

  // Saturating accumulate of the oldest product onto the running sum (or zero for a new group).
  always_comb begin
    p_ext    = ACC_WIDTH'(p_q[NUM_STAGE-1]);
    acc_base = acc_open_q ? acc_q : '0;
    ovf_base = acc_open_q & ovf_s_q;
    sum      = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(p_ext);
    clamped  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    if (clamped) begin
      sum_sat = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat = sum[ACC_WIDTH-1:0];
    end
  end

  // Output stage: forward products, update the accumulator, present finished dot products.
  always_comb begin
    out_vld_d  = out_vld_q;
    dout_d     = dout_q;
    dout_ovf_d = dout_ovf_q;
    acc_d      = acc_q;
    acc_open_d = acc_open_q;
    ovf_s_d    = ovf_s_q;
    if (adv) begin
      out_vld_d = 1'b0;
      if (vld_q[NUM_STAGE-1]) begin
        if (!mode_q[NUM_STAGE-1]) begin
          // Plain product: accumulator state is left alone so open groups survive.
          dout_d     = p_ext;
          dout_ovf_d = 1'b0;
          out_vld_d  = 1'b1;
        end else begin
          acc_d   = sum_sat;
          ovf_s_d = ovf_base | clamped;
          if (last_q[NUM_STAGE-1]) begin
            dout_d     = sum_sat;
            dout_ovf_d = ovf_base | clamped;
            out_vld_d  = 1'b1;
            acc_open_d = 1'b0;
          end else begin
            acc_open_d = 1'b1;
          end
        end
      end
    end
  end

  // Control and result registers; reset discards everything in flight.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q      <= '0;
      mode_q     <= '0;
      last_q     <= '0;
      out_vld_q  <= 1'b0;
      dout_q     <= '0;
      dout_ovf_q <= 1'b0;
      acc_q      <= '0;
      acc_open_q <= 1'b0;
      ovf_s_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      vld_q      <= vld_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      out_vld_q  <= out_vld_d;
      dout_q     <= dout_d;
      dout_ovf_q <= dout_ovf_d;
      acc_q      <= acc_d;
      acc_open_q <= acc_open_d;
      ovf_s_q    <= ovf_s_d;
    end
  end

  // Product payload registers.
  // NOTE: payload is qualified by vld_q, so it needs no reset and maps cleanly onto DSP pipeline registers.
  always_ff @(posedge ap_clk) begin
    p_q <= p_d;
  end

endmodule

// File: tb/tb_network_mac_pipe_signed.sv
// Directed bench for network_mac_pipe_signed (A=16, B=11, NUM_STAGE=3, ACC=27).
// The driver pushes hand-computed results into a scoreboard queue when a
// result-producing beat is accepted; a negedge monitor pops and compares.
module tb_network_mac_pipe_signed;

  localparam int  A_W    = 16;
  localparam int  B_W    = 11;
  localparam int  NS     = 3;
  localparam int  ACC_W  = 27;
  localparam time PERIOD = 10;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst;
  logic                    in_vld;
  logic                    in_rdy;
  logic signed [A_W-1:0]   din0;
  logic signed [B_W-1:0]   din1;
  logic                    in_mode;
  logic                    in_last;
  logic                    out_vld;
  logic                    out_rdy;
  logic signed [ACC_W-1:0] dout;
  logic                    dout_ovf;

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  exp_t   sb_q[$];
  time    out_t_q[$];
  int     checks = 0;
  int     errors = 0;
  int     n_pop  = 0;

  network_mac_pipe_signed #(
    .A_WIDTH  (A_W),
    .B_WIDTH  (B_W),
    .NUM_STAGE(NS),
    .ACC_WIDTH(ACC_W)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .din0    (din0),
    .din1    (din1),
    .in_mode (in_mode),
    .in_last (in_last),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .dout    (dout),
    .dout_ovf(dout_ovf)
  );

  always #(PERIOD/2) ap_clk = ~ap_clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance, and queue its expected result if it produces one.
  task automatic send(input int a, input int b, input bit m, input bit l,
                      input bit has_out, input longint exp_d, input bit exp_o,
                      output time t_acc);
    bit got = 1'b0;
    int n   = 0;
    t_acc   = 0;
    in_vld  = 1'b1;
    din0    = A_W'(a);
    din1    = B_W'(b);
    in_mode = m;
    in_last = l;
    while (!got && n < 200) begin
      @(negedge ap_clk);
      got = in_rdy;
      if (got) t_acc = $time;
      @(posedge ap_clk);
      n++;
    end
    if (!got) check("accept_timeout", 0, 1);
    else if (has_out) sb_q.push_back('{d: exp_d, o: exp_o});
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge ap_clk);
      n++;
    end
    repeat (3) @(posedge ap_clk);
    #1;
    check(name, longint'(sb_q.size()), 0);
  endtask

  // Monitor: compare every delivered result in order; watch the stall/in_rdy relation.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (out_vld && !out_rdy) check("in_rdy_during_stall", longint'(in_rdy), 0);
      if (out_vld && out_rdy) begin
        out_t_q.push_back($time);
        n_pop++;
        if (sb_q.size() == 0) begin
          check("unexpected_output", longint'(dout), 0);
          if (dout == '0) check("unexpected_output_vld", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("dout", longint'(dout), e.d);
          check("dout_ovf", longint'(dout_ovf), longint'(e.o));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    time tdummy;
    int  pop0;
    int ta[10] = '{1, -2, 100, -32768, 32767, 0, 7, -1, 255, -300};
    int tb[10] = '{1,  3, -100,  1023, -1024, 5, 7, -1,   4,   -2};
    longint tp[10] = '{1, -6, -10000, -33521664, -33553408, 0, 49, 1, 1020, 600};

    ap_rst  = 1'b1;
    in_vld  = 1'b0;
    din0    = '0;
    din1    = '0;
    in_mode = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b1;

    // Reset state
    @(negedge ap_clk);
    check("rst_out_vld", longint'(out_vld), 0);
    check("rst_dout", longint'(dout), 0);
    check("rst_ovf", longint'(dout_ovf), 0);
    check("rst_in_rdy", longint'(in_rdy), 0);
    @(posedge ap_clk); #2 ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // 1: mode-0 corner products and latency
    out_t_q.delete();
    send(-32768, -1024, 1'b0, 1'b0, 1'b1, 33554432, 1'b0, t0);
    send(32767, 1023, 1'b0, 1'b0, 1'b1, 33520641, 1'b0, tdummy);
    drain("drain_t1");
    if (out_t_q.size() >= 2) begin
      check("latency_first", longint'((out_t_q[0] - t0) / PERIOD), 4);
      check("latency_second", longint'((out_t_q[1] - t0) / PERIOD), 5);
    end else begin
      check("latency_outputs", longint'(out_t_q.size()), 2);
    end

    // 2: small dot product, only the last beat produces output
    pop0 = n_pop;
    send(3, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0, tdummy);
    send(5, -6, 1'b1, 1'b0, 1'b0, 0, 1'b0, tdummy);
    send(-7, 2, 1'b1, 1'b1, 1'b1, -32, 1'b0, tdummy);
    drain("drain_t2");
    check("t2_out_count", longint'(n_pop - pop0), 1);

    // 3: positive saturation, then a fresh group is clean
    for (int i = 0; i < 300; i++)
      send(32767, 1023, 1'b1, i == 299, i == 299, 67108863, 1'b1, tdummy);
    send(1, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0, tdummy);
    drain("drain_t3");

    // 3b: negative saturation
    for (int i = 0; i < 300; i++)
      send(-32768, 1023, 1'b1, i == 299, i == 299, -67108864, 1'b1, tdummy);
    send(-1, 1, 1'b1, 1'b1, 1'b1, -1, 1'b0, tdummy);
    drain("drain_t3b");

    // 4: stream of mode-0 beats under a 1,0,0 backpressure pattern
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(ta[i], tb[i], 1'b0, 1'b0, 1'b1, tp[i], 1'b0, tdummy);
      end
      begin
        for (int k = 0; k < 90; k++) begin
          out_rdy = (k % 3 == 0);
          @(posedge ap_clk); #1;
        end
        out_rdy = 1'b1;
      end
    join
    drain("drain_t4");
    check("t4_out_count", longint'(n_pop - pop0), 10);

    // 5: async reset in the middle of a group with a result held by stall
    out_rdy = 1'b0;
    send(3, 3, 1'b0, 1'b0, 1'b1, 9, 1'b0, tdummy);
    send(1, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0, tdummy);
    send(2, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, tdummy);
    begin
      int n = 0;
      while (!out_vld && n < 20) begin
        @(negedge ap_clk);
        n++;
      end
    end
    check("t5_held_before_rst", longint'(out_vld), 1);
    #1 ap_rst = 1'b1;
    #1;
    check("t5_out_vld_async", longint'(out_vld), 0);
    check("t5_in_rdy_in_rst", longint'(in_rdy), 0);
    check("t5_dout_cleared", longint'(dout), 0);
    sb_q.delete();
    @(posedge ap_clk); #2 ap_rst = 1'b0;
    out_rdy = 1'b1;
    @(posedge ap_clk); #1;
    send(2, 2, 1'b1, 1'b1, 1'b1, 4, 1'b0, tdummy);
    drain("drain_t5");

    // 6: mode-0 beat inside an open group
    send(1, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0, tdummy);
    send(10, 10, 1'b0, 1'b0, 1'b1, 100, 1'b0, tdummy);
    send(2, 2, 1'b1, 1'b1, 1'b1, 5, 1'b0, tdummy);
    drain("drain_t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
